aibio_pvtmon_seq: RTL and testbench

Measurement sequencer for the PVT monitor ripple counter chain. Holds the counter chain in reset, gates the monitor oscillator into it for a programmable window of reference clocks, waits for the ripple to settle, then captures the count and presents it over a valid/ack handshake. Sits between the digital control logic and the analog PVT monitor block, one instance per monitor.

---
 rtl/aibio_pvtmon_seq.sv | 209 ++++++++++++++++++++
 tb/tb_aibio_pvtmon_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aibio_pvtmon_seq.sv
// ============================================================================
//  Module   : aibio_pvtmon_seq
//  Purpose  : Measurement sequencer for the PVT monitor ripple counter chain.
//             Clears the chain, gates the monitor oscillator into it for a
//             programmable window, lets the ripple settle, captures the count
//             and presents it over a valid/ack handshake.
//  Ports    : clk, rst          - reference clock, synchronous active-high reset
//             start, cont       - measurement request / continuous re-arm
//             win_len           - window length in clk cycles (0 acts as 1)
//             ctr_val           - asynchronous count from the counter chain
//             ack               - consumer accepts meas_data
//             ctr_rb, osc_en    - counter reset (active-low) / oscillator gate
//             busy              - sequencer not idle
//             meas_valid/data/sat - captured result and all-ones flag
//             thr_hi/lo, alarm_hi/lo - optional threshold compare
//  Options  : `define AIBIO_PVTMON_SEQ_ALARM_EN enables the threshold alarms;
//             otherwise the alarms are tied low and thresholds are unused.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aibio_pvtmon_seq #(
    parameter int CNT_W      = 10,
    parameter int WIN_W      = 12,
    parameter int CLR_CYC    = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] ctr_val,
    input  logic             ack,
    output logic             ctr_rb,
    output logic             osc_en,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_data,
    output logic             meas_sat,
    output logic             alarm_hi,
    output logic             alarm_lo,
    input  logic [CNT_W-1:0] thr_hi,
    input  logic [CNT_W-1:0] thr_lo
);

    // Timer width: wide enough for any window length and for the fixed
    // clear / settle intervals (the timer holds "cycles remaining - 1").
    localparam int c_CLR_W    = (CLR_CYC > 1)    ? $clog2(CLR_CYC)    : 1;
    localparam int c_SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int c_FIX_W    = (c_CLR_W > c_SETTLE_W) ? c_CLR_W : c_SETTLE_W;
    localparam int c_TMR_W    = (WIN_W > c_FIX_W) ? WIN_W : c_FIX_W;

    localparam logic [c_TMR_W-1:0] c_CLR_LOAD    = c_TMR_W'(CLR_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_SETTLE_LOAD = c_TMR_W'(SETTLE_CYC - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CLR     = 3'd1;
    localparam logic [2:0] c_COUNT   = 3'd2;
    localparam logic [2:0] c_SETTLE  = 3'd3;
    localparam logic [2:0] c_CAPTURE = 3'd4;
    localparam logic [2:0] c_HOLD    = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_TMR_W-1:0] r_tmr;
    logic [c_TMR_W-1:0] w_tmr_next;
    logic [WIN_W-1:0]   r_win;
    logic               w_win_load;
    logic [WIN_W-1:0]   w_win_m1;
    logic [c_TMR_W-1:0] w_count_load;

    logic               r_ctr_rb;
    logic               r_osc_en;
    logic               r_busy;
    logic               r_valid;
    logic [CNT_W-1:0]   r_data;
    logic               r_sat;

    // A zero window length is promoted to one cycle.
    assign w_win_m1     = (r_win == '0) ? '0 : (r_win - WIN_W'(1));
    assign w_count_load = c_TMR_W'(w_win_m1);

    // Next-state / timer logic. The timer is loaded on every entry into a
    // timed state and counts down to zero, so it never wraps.
    always_comb begin
        w_next_state = r_state;
        w_tmr_next   = r_tmr;
        w_win_load   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next_state = c_CLR;
                    w_tmr_next   = c_CLR_LOAD;
                    w_win_load   = 1'b1;
                end
            end
            c_CLR: begin
                if (r_tmr == '0) begin
                    w_next_state = c_COUNT;
                    w_tmr_next   = w_count_load;
                end else begin
                    w_tmr_next = r_tmr - c_TMR_W'(1);
                end
            end
            c_COUNT: begin
                if (r_tmr == '0) begin
                    w_next_state = c_SETTLE;
                    w_tmr_next   = c_SETTLE_LOAD;
                end else begin
                    w_tmr_next = r_tmr - c_TMR_W'(1);
                end
            end
            c_SETTLE: begin
                if (r_tmr == '0) begin
                    w_next_state = c_CAPTURE;
                    w_tmr_next   = '0;
                end else begin
                    w_tmr_next = r_tmr - c_TMR_W'(1);
                end
            end
            c_CAPTURE: begin
                w_next_state = c_HOLD;
            end
            c_HOLD: begin
                if (ack) begin
                    if (cont) begin
                        w_next_state = c_CLR;
                        w_tmr_next   = c_CLR_LOAD;
                        w_win_load   = 1'b1;
                    end else begin
                        w_next_state = c_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = c_IDLE;
                w_tmr_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so that osc_en and ctr_rb
    // come straight off flops and can never glitch into the counter chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_tmr    <= '0;
            r_win    <= '0;
            r_ctr_rb <= 1'b0;
            r_osc_en <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_sat    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_tmr    <= w_tmr_next;
            if (w_win_load) begin
                r_win <= win_len;
            end
            r_ctr_rb <= (w_next_state == c_COUNT)   || (w_next_state == c_SETTLE) ||
                        (w_next_state == c_CAPTURE) || (w_next_state == c_HOLD);
            r_osc_en <= (w_next_state == c_COUNT);
            r_busy   <= (w_next_state != c_IDLE);
            r_valid  <= (w_next_state == c_HOLD);
            // The chain has been frozen for the whole settle interval, so
            // the asynchronous count is stable when sampled here.
            if (r_state == c_CAPTURE) begin
                r_data <= ctr_val;
                r_sat  <= &ctr_val;
            end
        end
    end

    assign ctr_rb     = r_ctr_rb;
    assign osc_en     = r_osc_en;
    assign busy       = r_busy;
    assign meas_valid = r_valid;
    assign meas_data  = r_data;
    assign meas_sat   = r_sat;

`ifdef AIBIO_PVTMON_SEQ_ALARM_EN
    logic r_alarm_hi;
    logic r_alarm_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alarm_hi <= 1'b0;
            r_alarm_lo <= 1'b0;
        end else if (r_state == c_CAPTURE) begin
            r_alarm_hi <= (ctr_val > thr_hi);
            r_alarm_lo <= (ctr_val < thr_lo);
        end
    end

    assign alarm_hi = r_alarm_hi;
    assign alarm_lo = r_alarm_lo;
`else
    // Thresholds are deliberately left unloaded in this build.
    logic w_unused_thr;
    assign w_unused_thr = ^{thr_hi, thr_lo};
    assign alarm_hi     = 1'b0;
    assign alarm_lo     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aibio_pvtmon_seq.sv
// ============================================================================
//  Module   : tb_aibio_pvtmon_seq
//  Purpose  : Self-checking bench for aibio_pvtmon_seq. A stimulus process
//             issues measurements and pushes the expected result into a
//             scoreboard queue; a monitor pops and compares when meas_valid
//             rises and checks hold/gating behaviour every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aibio_pvtmon_seq;

    localparam int CNT_W      = 10;
    localparam int WIN_W      = 12;
    localparam int CLR_CYC    = 2;
    localparam int SETTLE_CYC = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             cont = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic [CNT_W-1:0] ctr_val;
    logic             ack = 1'b0;
    logic             ctr_rb, osc_en, busy, meas_valid, meas_sat;
    logic [CNT_W-1:0] meas_data;
    logic             alarm_hi, alarm_lo;
    logic [CNT_W-1:0] thr_hi = '0;
    logic [CNT_W-1:0] thr_lo = '0;

    aibio_pvtmon_seq #(
        .CNT_W(CNT_W), .WIN_W(WIN_W), .CLR_CYC(CLR_CYC), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .win_len(win_len),
        .ctr_val(ctr_val), .ack(ack), .ctr_rb(ctr_rb), .osc_en(osc_en),
        .busy(busy), .meas_valid(meas_valid), .meas_data(meas_data),
        .meas_sat(meas_sat), .alarm_hi(alarm_hi), .alarm_lo(alarm_lo),
        .thr_hi(thr_hi), .thr_lo(thr_lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Counter-chain model: cleared while ctr_rb is low, advances by m_step
    // per reference cycle while the oscillator is gated in.
    int unsigned osc_cnt = 0;
    int unsigned m_base  = 0;
    int unsigned m_step  = 0;
    always @(posedge clk) begin
        if (!ctr_rb)     osc_cnt <= 0;
        else if (osc_en) osc_cnt <= osc_cnt + 1;
    end
    always_comb ctr_val = CNT_W'(m_base + m_step * osc_cnt);

    typedef struct {
        int               t0;
        int               n;
        logic [CNT_W-1:0] data;
        logic             sat;
        logic             ahi;
        logic             alo;
    } exp_t;
    exp_t sb[$];

    // Sets up the next measurement and records what it must produce. The
    // request (start or ack) is sampled at the next rising edge.
    task automatic arm(input int wl, input int unsigned base, input int unsigned step,
                       input logic [CNT_W-1:0] thi, input logic [CNT_W-1:0] tlo);
        exp_t e;
        win_len = WIN_W'(wl);
        thr_hi  = thi;
        thr_lo  = tlo;
        m_base  = base;
        m_step  = step;
        e.t0    = cyc + 1;
        e.n     = (wl == 0) ? 1 : wl;
        e.data  = CNT_W'(base + step * e.n);
        e.sat   = (e.data == {CNT_W{1'b1}});
`ifdef AIBIO_PVTMON_SEQ_ALARM_EN
        e.ahi   = (e.data > thi);
        e.alo   = (e.data < tlo);
`else
        e.ahi   = 1'b0;
        e.alo   = 1'b0;
`endif
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_valid();
        int i;
        for (i = 0; i < 400; i++) begin
            if (meas_valid) break;
            tick(1);
        end
        if (i == 400) chk("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_ack();
        logic c;
        c   = cont;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("ack_valid_drop", meas_valid, 1'b0);
        if (c) chk("ack_cont_clr", {ctr_rb, busy}, 2'b01);
        else   chk("ack_idle", {ctr_rb, busy}, 2'b00);
    endtask

    // Monitor
    bit               pv = 0;
    int               osc_len = 0, osc_rise = 0, last_len = 0, last_rise = 0;
    logic [CNT_W-1:0] held = '0;
    exp_t             me;

    always @(negedge clk) begin
        if (rst) begin
            pv      = 0;
            osc_len = 0;
        end else begin
            if (osc_en) begin
                if (osc_len == 0) osc_rise = cyc;
                osc_len++;
                chk("osc_while_cleared", ctr_rb, 1'b1);
            end else if (osc_len != 0) begin
                last_len  = osc_len;
                last_rise = osc_rise;
                osc_len   = 0;
            end
            if (meas_valid && !pv) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    me = sb.pop_front();
                    chk("meas_data", meas_data, me.data);
                    chk("meas_sat", meas_sat, me.sat);
                    chk("alarms", {alarm_hi, alarm_lo}, {me.ahi, me.alo});
                    chk("valid_latency", cyc - me.t0, CLR_CYC + me.n + SETTLE_CYC + 1);
                    chk("osc_window", last_len, me.n);
                    chk("osc_start", last_rise - me.t0, CLR_CYC);
                    held = meas_data;
                end
            end else if (meas_valid) begin
                chk("hold_stable", {meas_data == held, ctr_rb, osc_en, busy}, 4'b1101);
            end
            pv = meas_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        // Reset state
        tick(3);
        chk("reset_outputs", {ctr_rb, osc_en, busy, meas_valid, meas_sat, alarm_hi, alarm_lo}, 7'd0);
        chk("reset_data", meas_data, 10'd0);
        rst = 1'b0;
        tick(2);

        // Single shot, default window
        arm(100, 32'h2A5, 0, 10'h3FF, 10'h000);
        pulse_start();
        chk("start_busy_clr", {busy, ctr_rb}, 2'b10);
        wait_valid();
        tick(2);
        do_ack();

        // Zero window
        arm(0, 32'h100, 7, 10'h3FF, 10'h000);
        pulse_start();
        wait_valid();
        do_ack();

        // Saturation and high alarm
        arm(10, 32'h3FF, 0, 10'h300, 10'h000);
        pulse_start();
        wait_valid();
        do_ack();
        chk("sat_held_idle", {meas_sat, meas_data}, {1'b1, 10'h3FF});

        // Low alarm, no saturation
        arm(5, 32'h010, 0, 10'h3FF, 10'h020);
        pulse_start();
        wait_valid();
        do_ack();

        // Handshake: long hold with an ignored start
        arm(30, 32'h055, 3, 10'h080, 10'h070);
        pulse_start();
        wait_valid();
        tick(25);
        pulse_start();
        tick(25);
        do_ack();
        tick(3);
        chk("start_in_hold_ignored", busy, 1'b0);

        // Continuous mode
        cont = 1'b1;
        arm(20, 32'h0, 5, 10'h050, 10'h010);
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            wait_valid();
            tick($urandom_range(0, 3));
            arm(20, $urandom, $urandom_range(0, 40), 10'($urandom), 10'($urandom));
            do_ack();
        end
        for (int i = 0; i < 100 && !osc_en; i++) tick(1);
        chk("cont_third_counting", osc_en, 1'b1);
        cont = 1'b0;
        wait_valid();
        do_ack();

        // Randomized measurements with ignored start/ack and win_len changes
        for (int k = 0; k < 8; k++) begin
            arm($urandom_range(0, 40), $urandom, $urandom_range(0, 40),
                10'($urandom), 10'($urandom));
            pulse_start();
            tick($urandom_range(0, 4));
            win_len = WIN_W'($urandom);
            start   = 1'b1;
            ack     = 1'b1;
            tick(1);
            start   = 1'b0;
            ack     = 1'b0;
            wait_valid();
            tick($urandom_range(0, 4));
            do_ack();
        end

        // Reset in the middle of a window
        arm(100, 32'h155, 1, 10'h3FF, 10'h000);
        pulse_start();
        tick(20);
        chk("pre_reset_osc", osc_en, 1'b1);
        rst = 1'b1;
        tick(1);
        chk("midrun_reset_outputs", {ctr_rb, osc_en, busy, meas_valid, meas_sat, alarm_hi, alarm_lo}, 7'd0);
        chk("midrun_reset_data", meas_data, 10'd0);
        tick(2);
        rst = 1'b0;
        sb.delete();
        tick(150);
        chk("post_reset_idle", {busy, meas_valid}, 2'b00);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
